// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit-opcode CPU: opcodes, sequencer states,
// datapath mux encodings and the ALU-control decode used by every decoder.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0, OP_ST  = 4'h3, OP_ADD = 4'h4, OP_INC = 4'h5,
                           OP_NEG  = 4'h6, OP_SUB = 4'h7, OP_J   = 4'h8, OP_BRZ = 4'h9,
                           OP_JM   = 4'hA, OP_BRN = 4'hB, OP_LD  = 4'hE, OP_SVPC = 4'hF;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        ERR    = 3'd7
    } state_t;

    localparam logic [1:0] PC_INC  = 2'b00, PC_RS   = 2'b01, PC_DMEM  = 2'b10;
    localparam logic [1:0] WB_ALU  = 2'b00, WB_DMEM = 2'b01, WB_PCIMM = 2'b10;
    localparam logic [2:0] ALU_NOP = 3'b000, ALU_ADD = 3'b001, ALU_NEG = 3'b010,
                           ALU_SUB = 3'b100;

    function automatic logic op_is_legal(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'hC, 4'hD: return 1'b0;
            default:                return 1'b1;
        endcase
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        case (op)
            OP_ADD, OP_INC, OP_NEG, OP_SUB: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // SVPC reuses the adder to form pc+imm
    function automatic logic [2:0] op_aluop(input logic [3:0] op);
        case (op)
            OP_ADD, OP_INC, OP_SVPC: return ALU_ADD;
            OP_NEG:                  return ALU_NEG;
            OP_SUB:                  return ALU_SUB;
            default:                 return ALU_NOP;
        endcase
    endfunction

    function automatic logic op_alusrc(input logic [3:0] op);
        return (op == OP_INC) || (op == OP_SVPC);
    endfunction

endpackage

// File: rtl/hs_timeout.sv
// Wait counter for a req/ack handshake; flags expiry on the cycle the count
// would reach TIMEOUT with no ack. TIMEOUT=0 disables expiry.
module hs_timeout #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic req,
    input  logic ack,
    output logic expire
);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_reg + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (req && !ack) begin
            cnt_reg <= cnt_inc;
        end
    end

    // An ack in the final cycle wins over expiry
    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            assign expire = req && !ack && (cnt_inc == CNT_W'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: fetch/decode/exec/mem/wb sequencing around the
// instruction and data memory handshakes, with run/halt, flags and bus timeout.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        alu_z,
    input  logic        alu_n,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        alusrc,
    output logic [2:0]  aluop,
    output logic        illegal,
    output logic        bus_err,
    output logic [2:0]  state
);

    state_t      state_reg, state_next;
    logic [31:0] ir_reg, ir_next;
    logic        z_reg, z_next, n_reg, n_next;
    logic        illegal_reg, illegal_next;
    logic        bus_err_reg, bus_err_next;
    logic        fetch_pend_reg, fetch_pend_next;
    logic [3:0]  op;
    logic        hs_req, hs_ack, hs_clear, hs_expire;

    assign op = ir_reg[31:28];

    // Once raised, the fetch request is held regardless of run until ack/timeout
    assign imem_req = (state_reg == FETCH) && !rst && (run || fetch_pend_reg);
    assign dmem_req = (state_reg == MEM);

    assign hs_req   = imem_req || dmem_req;
    assign hs_ack   = (state_reg == MEM) ? dmem_ack : imem_ack;
    assign hs_clear = (state_next != state_reg) && ((state_next == FETCH) || (state_next == MEM));

    hs_timeout #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_hs_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (hs_clear),
        .req    (hs_req),
        .ack    (hs_ack),
        .expire (hs_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= FETCH;
            ir_reg         <= '0;
            z_reg          <= 1'b0;
            n_reg          <= 1'b0;
            illegal_reg    <= 1'b0;
            bus_err_reg    <= 1'b0;
            fetch_pend_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ir_reg         <= ir_next;
            z_reg          <= z_next;
            n_reg          <= n_next;
            illegal_reg    <= illegal_next;
            bus_err_reg    <= bus_err_next;
            fetch_pend_reg <= fetch_pend_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        ir_next         = ir_reg;
        z_next          = z_reg;
        n_next          = n_reg;
        illegal_next    = illegal_reg;
        bus_err_next    = bus_err_reg;
        fetch_pend_next = 1'b0;
        pc_we           = 1'b0;
        pc_sel          = PC_INC;
        reg_we          = 1'b0;
        wb_sel          = WB_ALU;
        dmem_we         = 1'b0;
        alusrc          = 1'b0;
        aluop           = ALU_NOP;

        if (state_reg inside {DECODE, EXEC, MEM, WB}) begin
            aluop  = op_aluop(op);
            alusrc = op_alusrc(op);
        end

        case (state_reg)
            FETCH: begin
                fetch_pend_next = imem_req && !imem_ack && !hs_expire;
                if (imem_req && imem_ack) begin
                    ir_next    = imem_rdata;
                    state_next = DECODE;
                end else if (hs_expire) begin
                    bus_err_next = 1'b1;
                    state_next   = ERR;
                end
            end
            DECODE: begin
                if (!op_is_legal(op)) begin
                    illegal_next = 1'b1;
                    pc_we        = 1'b1;
                    state_next   = FETCH;
                end else begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (op_sets_flags(op)) begin
                    z_next = alu_z;
                    n_next = alu_n;
                end
                case (op)
                    OP_ADD, OP_INC, OP_NEG, OP_SUB, OP_SVPC: state_next = WB;
                    OP_LD, OP_ST, OP_JM:                     state_next = MEM;
                    OP_J: begin
                        pc_we      = 1'b1;
                        pc_sel     = PC_RS;
                        state_next = FETCH;
                    end
                    OP_BRZ: begin
                        pc_we      = 1'b1;
                        pc_sel     = z_reg ? PC_RS : PC_INC;
                        state_next = FETCH;
                    end
                    OP_BRN: begin
                        pc_we      = 1'b1;
                        pc_sel     = n_reg ? PC_RS : PC_INC;
                        state_next = FETCH;
                    end
                    default: begin
                        pc_we      = 1'b1;
                        state_next = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_we = (op == OP_ST);
                if (dmem_ack) begin
                    case (op)
                        OP_LD: state_next = WB;
                        OP_JM: begin
                            pc_we      = 1'b1;
                            pc_sel     = PC_DMEM;
                            state_next = FETCH;
                        end
                        default: begin
                            pc_we      = 1'b1;
                            state_next = FETCH;
                        end
                    endcase
                end else if (hs_expire) begin
                    bus_err_next = 1'b1;
                    state_next   = ERR;
                end
            end
            WB: begin
                reg_we     = 1'b1;
                wb_sel     = (op == OP_LD) ? WB_DMEM : ((op == OP_SVPC) ? WB_PCIMM : WB_ALU);
                pc_we      = 1'b1;
                state_next = FETCH;
            end
            ERR:     state_next = ERR;
            default: state_next = FETCH;
        endcase
    end

    assign ir      = ir_reg;
    assign illegal = illegal_reg;
    assign bus_err = bus_err_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized instruction-level bench for multicycle_sequencer with an
// instruction-granular reference model of timing and strobe results.
module tb_multicycle_sequencer;

    logic        clk, rst, run, imem_ack, dmem_ack, alu_z, alu_n;
    logic [31:0] imem_rdata, ir;
    logic        imem_req, dmem_req, dmem_we, pc_we, reg_we, alusrc, illegal, bus_err;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  aluop, state;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_txn    = 0;
    logic m_z, m_n, m_ill;

    multicycle_sequencer #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .ir(ir),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_z(alu_z), .alu_n(alu_n),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alusrc(alusrc), .aluop(aluop), .illegal(illegal), .bus_err(bus_err),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: per-opcode results straight from the instruction table
    function automatic bit m_undef(input logic [3:0] op);
        return (op == 4'h1) || (op == 4'h2) || (op == 4'hC) || (op == 4'hD);
    endfunction

    function automatic int m_cycles(input logic [3:0] op, input int fd, input int dd);
        case (op)
            4'h1, 4'h2, 4'hC, 4'hD:        return fd + 2;
            4'h0, 4'h8, 4'h9, 4'hB:        return fd + 3;
            4'h4, 4'h5, 4'h6, 4'h7, 4'hF:  return fd + 4;
            4'h3, 4'hA:                    return fd + 4 + dd;
            default:                       return fd + 5 + dd;
        endcase
    endfunction

    function automatic int m_pcsel(input logic [3:0] op);
        case (op)
            4'h8:    return 1;
            4'h9:    return m_z ? 1 : 0;
            4'hB:    return m_n ? 1 : 0;
            4'hA:    return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int m_aluop(input logic [3:0] op);
        case (op)
            4'h4, 4'h5, 4'hF: return 1;
            4'h6:             return 2;
            4'h7:             return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic int m_regw(input logic [3:0] op);
        return (op inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE, 4'hF}) ? 1 : 0;
    endfunction

    function automatic int m_wbsel(input logic [3:0] op);
        return (op == 4'hE) ? 1 : ((op == 4'hF) ? 2 : 0);
    endfunction

    function automatic int m_dreq(input logic [3:0] op, input int dd);
        return (op inside {4'h3, 4'hA, 4'hE}) ? dd + 1 : 0;
    endfunction

    function automatic int pick_delay();
        return ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
    endfunction

    task automatic do_reset();
        rst = 1'b1; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        imem_rdata = '0; alu_z = 1'b0; alu_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_ir", ir, 32'd0);
        check_eq("rst_sticky", 32'({illegal, bus_err}), 32'd0);
        check_eq("rst_strobes", 32'({imem_req, dmem_req, dmem_we, pc_we, reg_we}), 32'd0);
        check_eq("rst_sels", 32'({pc_sel, wb_sel, alusrc, aluop}), 32'd0);
        @(negedge clk);
        rst = 1'b0; run = 1'b0;
        m_z = 1'b0; m_n = 1'b0; m_ill = 1'b0;
    endtask

    task automatic exec_instr(input logic [31:0] inst, input int fd, input int dd,
                              input logic az, input logic an);
        logic [3:0]  op;
        int          c, ireq, dreq, regw, req_drop, dwe_bad;
        bit          fetched, daccess, done;
        logic [1:0]  got_pcsel, got_wbsel;
        logic [2:0]  got_aluop;
        logic        got_alusrc;
        logic [31:0] got_ir;
        op = inst[31:28];
        c = 0; ireq = 0; dreq = 0; regw = 0; req_drop = 0; dwe_bad = 0;
        fetched = 0; daccess = 0; done = 0;
        got_pcsel = '0; got_wbsel = '0; got_aluop = '0; got_alusrc = 1'b0; got_ir = '0;
        while (!done && c < 80) begin
            @(negedge clk);
            run        = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            imem_ack   = !fetched && (ireq == fd);
            imem_rdata = imem_ack ? inst : $urandom;
            dmem_ack   = !daccess && (dreq == dd);
            alu_z      = (c == fd + 2) ? az : 1'($urandom);
            alu_n      = (c == fd + 2) ? an : 1'($urandom);
            #1;
            if (c == 0) begin
                check_eq("start_state", 32'(state), 32'd0);
                check_eq("illegal_sticky", 32'(illegal), 32'(m_ill));
                check_eq("bus_err_clear", 32'(bus_err), 32'd0);
            end
            if (imem_req) ireq++;
            else if (!fetched) req_drop++;
            if (imem_req && imem_ack) fetched = 1;
            if (dmem_req) begin
                dreq++;
                if (dmem_we != (op == 4'h3)) dwe_bad++;
                if (dmem_ack) daccess = 1;
            end
            if (reg_we) begin
                regw++;
                got_wbsel = wb_sel;
            end
            if (pc_we) begin
                done       = 1;
                got_pcsel  = pc_sel;
                got_aluop  = aluop;
                got_alusrc = alusrc;
                got_ir     = ir;
            end
            c++;
        end
        check_eq("instr_done", 32'(done), 32'd1);
        check_eq("cycles", 32'(c), 32'(m_cycles(op, fd, dd)));
        check_eq("ir", got_ir, inst);
        check_eq("imem_req_cycles", 32'(ireq), 32'(fd + 1));
        check_eq("imem_req_drop", 32'(req_drop), 32'd0);
        check_eq("pc_sel", 32'(got_pcsel), 32'(m_undef(op) ? 0 : m_pcsel(op)));
        check_eq("reg_we_count", 32'(regw), 32'(m_regw(op)));
        if (regw != 0) check_eq("wb_sel", 32'(got_wbsel), 32'(m_wbsel(op)));
        check_eq("aluop", 32'(got_aluop), 32'(m_aluop(op)));
        check_eq("alusrc", 32'(got_alusrc), 32'((op == 4'h5) || (op == 4'hF)));
        check_eq("dmem_req_cycles", 32'(dreq), 32'(m_dreq(op, dd)));
        check_eq("dmem_we", 32'(dwe_bad), 32'd0);
        $display("txn %0d inst=%08h fd=%0d dd=%0d cycles=%0d pc_sel=%0d reg_we=%0d",
                 n_txn, inst, fd, dd, c, got_pcsel, regw);
        n_txn++;
        if (m_undef(op)) m_ill = 1'b1;
        if (op inside {4'h4, 4'h5, 4'h6, 4'h7}) begin
            m_z = az;
            m_n = an;
        end
    endtask

    task automatic timeout_test();
        int c, first_req, err_at, dcnt;
        logic [4:0] strobes;
        c = 0; first_req = -1; err_at = -1; dcnt = 0;
        while (err_at < 0 && c < 60) begin
            @(negedge clk);
            run = 1'b1; imem_ack = (c == 0); imem_rdata = 32'h3000_0000;
            dmem_ack = 1'b0;
            #1;
            if (dmem_req) begin
                dcnt++;
                if (first_req < 0) first_req = c;
            end
            if (bus_err) err_at = c;
            c++;
        end
        check_eq("timeout_latency", 32'(err_at - first_req), 32'd16);
        check_eq("timeout_req_cycles", 32'(dcnt), 32'd16);
        strobes = '0;
        repeat (8) begin
            @(negedge clk);
            imem_ack = 1'($urandom); dmem_ack = 1'($urandom);
            #1;
            strobes |= {imem_req, dmem_req, dmem_we, pc_we, reg_we};
        end
        check_eq("err_state", 32'(state), 32'd7);
        check_eq("err_strobes", 32'(strobes), 32'd0);
        check_eq("err_bus_err", 32'(bus_err), 32'd1);
        $display("txn %0d timeout: bus_err after %0d cycles of dmem_req", n_txn, err_at - first_req);
        n_txn++;
    endtask

    task automatic run_low_test();
        int reqs;
        reqs = 0;
        repeat (20) begin
            @(negedge clk);
            run = 1'b0; imem_ack = 1'($urandom); imem_rdata = $urandom;
            #1;
            if (imem_req) reqs++;
        end
        check_eq("run0_imem_req", 32'(reqs), 32'd0);
        check_eq("run0_state", 32'(state), 32'd0);
        check_eq("run0_ir", ir, 32'd0);
        $display("txn %0d run=0 idle: imem_req cycles=%0d", n_txn, reqs);
        n_txn++;
    endtask

    task automatic async_reset_test();
        int c;
        bit in_mem;
        c = 0; in_mem = 0;
        while (!in_mem && c < 10) begin
            @(negedge clk);
            run = 1'b1; imem_ack = (c == 0); imem_rdata = 32'hE000_0042; dmem_ack = 1'b0;
            #1;
            in_mem = dmem_req;
            c++;
        end
        check_eq("mem_reached", 32'(in_mem), 32'd1);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_state", 32'(state), 32'd0);
        check_eq("async_ir", ir, 32'd0);
        check_eq("async_strobes", 32'({imem_req, dmem_req, dmem_we, pc_we, reg_we}), 32'd0);
        $display("txn %0d async reset during MEM wait", n_txn);
        n_txn++;
        do_reset();
    endtask

    initial begin
        logic [31:0] inst;
        do_reset();
        exec_instr(32'h4123_4567, 0, 0, 1'b0, 1'b0);
        exec_instr(32'h7000_0001, 0, 0, 1'b1, 1'b0);
        exec_instr(32'h9000_0010, 0, 0, 1'b0, 1'b0);
        exec_instr(32'h7000_0002, 0, 0, 1'b0, 1'b1);
        exec_instr(32'h9000_0020, 0, 0, 1'b1, 1'b1);
        exec_instr(32'hB000_0030, 1, 0, 1'b0, 1'b0);
        exec_instr(32'hE000_0040, 0, 3, 1'b0, 1'b0);
        exec_instr(32'hC000_0000, 0, 0, 1'b0, 1'b0);
        exec_instr(32'h5000_0001, 15, 0, 1'b0, 1'b0);
        exec_instr(32'hA000_0050, 2, 15, 1'b0, 1'b0);
        exec_instr(32'h3000_0060, 0, 0, 1'b0, 1'b0);
        exec_instr(32'hF000_0070, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 150; i++) begin
            inst = $urandom;
            exec_instr(inst, pick_delay(), pick_delay(), 1'($urandom), 1'($urandom));
        end
        timeout_test();
        do_reset();
        run_low_test();
        exec_instr(32'h6000_0000, 0, 0, 1'b1, 1'b1);
        async_reset_test();
        exec_instr(32'h4000_0001, 0, 0, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
